// File: rtl/digit_scanner.sv
// Time-multiplexed scanner for a 4-digit display: drives a 2-to-4 decoder index
// and blanks the decoder between digits so the outgoing and incoming digits never overlap.
module digit_scanner #(
  parameter int SHOW_CYC  = 50000,
  parameter int BLANK_CYC = 4,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] mask,
  output logic       o1,
  output logic       o0,
  output logic       blank,
  output logic       digit_done,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [1:0]       nxt_idx;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    lowest_set = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) lowest_set = 2'(i);
    end
  endfunction

  // Circular search starting at cur+1; cur itself is the last candidate, so a
  // lone enabled digit keeps being selected.
  function automatic logic [1:0] next_set(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] cand;
    next_set = cur;
    for (int k = 4; k >= 1; k--) begin
      cand = cur + 2'(k);
      if (m[cand]) next_set = cand;
    end
  endfunction

  assign nxt_idx = next_set(idx, mask);
  assign {o1, o0} = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= 2'd0;
      blank      <= 1'b1;
      digit_done <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      digit_done <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          blank <= 1'b1;
          cnt   <= '0;
          if (en && mask != 4'b0000) begin
            state <= SHOW;
            idx   <= lowest_set(mask);
            blank <= 1'b0;
          end
        end
        SHOW: begin
          if (!en) begin
            state <= IDLE;
            blank <= 1'b1;
            cnt   <= '0;
          end else if (cnt == SHOW_LAST) begin
            state      <= BLANK;
            blank      <= 1'b1;
            cnt        <= '0;
            digit_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BLANK: begin
          if (!en) begin
            state <= IDLE;
            blank <= 1'b1;
            cnt   <= '0;
          end else if (cnt == BLANK_LAST) begin
            cnt <= '0;
            if (mask != 4'b0000) begin
              state      <= SHOW;
              blank      <= 1'b0;
              idx        <= nxt_idx;
              frame_done <= (nxt_idx <= idx);
            end else begin
              state <= IDLE;
              blank <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          blank <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_scanner.sv
// Scoreboard bench for digit_scanner with SHOW_CYC=4, BLANK_CYC=2: the stimulus
// thread queues the expected outputs for each cycle and a monitor pops and compares them.
module tb_digit_scanner;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] mask;
  logic       o1, o0, blank, digit_done, frame_done;

  typedef struct {
    logic [1:0] idx;
    logic       blank;
    logic       dd;
    logic       fd;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;

  digit_scanner #(.SHOW_CYC(4), .BLANK_CYC(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .mask(mask),
    .o1(o1), .o0(o0), .blank(blank),
    .digit_done(digit_done), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got {idx,blank,dd,fd}=%b_%b%b%b expected %b_%b%b%b",
                  nm, act[4:3], act[2], act[1], act[0], exp[4:3], exp[2], exp[1], exp[0]);
  endtask

  // Inputs applied now are sampled at the next rising edge; the pushed entry
  // describes the outputs right after that edge.
  task automatic applyStimulus(input logic e, input logic [3:0] m, input logic [1:0] ei,
                               input logic eb, input logic edd, input logic efd, input string nm);
    exp_t x;
    @(posedge clk);
    #2;
    en   = e;
    mask = m;
    x.idx = ei; x.blank = eb; x.dd = edd; x.fd = efd; x.name = nm;
    sb.push_back(x);
  endtask

  // Steady scan from IDLE: each digit is 4 shown + 2 blank cycles, and a frame
  // wraps whenever the ascending digit list restarts.
  task automatic runPattern(input logic [3:0] m, input logic [7:0] seqp, input int n,
                            input int cycles, input string nm);
    int slot, ph;
    logic [1:0] d;
    for (int t = 0; t < cycles; t++) begin
      slot = t / 6;
      ph   = t % 6;
      d    = seqp[2*(slot % n) +: 2];
      applyStimulus(1'b1, m, d, ph >= 4, ph == 4, ph == 0 && t > 0 && (slot % n) == 0, nm);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        checkOutput(mon_e.name, {o1, o0, blank, digit_done, frame_done},
                    {mon_e.idx, mon_e.blank, mon_e.dd, mon_e.fd});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int u;
    rst  = 1'b1;
    en   = 1'b0;
    mask = 4'b0000;
    #1;
    checkOutput("reset_values", {o1, o0, blank, digit_done, frame_done}, 5'b00_100);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, "idle_after_reset");

    runPattern(4'b1111, {2'd3, 2'd2, 2'd1, 2'd0}, 4, 25, "scan1111");
    applyStimulus(1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, "idle_hold0");

    runPattern(4'b1010, {2'd0, 2'd0, 2'd3, 2'd1}, 2, 25, "scan1010");
    applyStimulus(1'b0, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, "idle_hold1");

    // Mask cleared during SHOW of digit 1: finish the digit, blank, then IDLE.
    for (int t = 0; t < 14; t++) begin
      if (t <= 11)
        applyStimulus(1'b1, (t >= 8) ? 4'b0000 : 4'b1111, 2'(t / 6), (t % 6) >= 4,
                      (t % 6) == 4, 1'b0, "mask_clear");
      else
        applyStimulus(1'b1, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, "mask_clear_idle");
    end
    applyStimulus(1'b0, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, "idle_hold1b");

    // en dropped in cycle 2 of digit 3, resumed 5 cycles later with mask 0110.
    for (int t = 0; t < 32; t++) begin
      if (t < 20)
        applyStimulus(1'b1, 4'b1111, 2'(t / 6), (t % 6) >= 4, (t % 6) == 4, 1'b0, "en_drop_scan");
      else if (t < 25)
        applyStimulus(1'b0, 4'b1111, 2'd3, 1'b1, 1'b0, 1'b0, "en_drop_idle");
      else begin
        u = t - 25;
        applyStimulus(1'b1, 4'b0110, (u < 6) ? 2'd1 : 2'd2, (u % 6) >= 4, u == 4, 1'b0, "en_resume");
      end
    end
    applyStimulus(1'b0, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, "idle_hold2");

    runPattern(4'b0100, {2'd0, 2'd0, 2'd0, 2'd2}, 1, 13, "scan0100");

    @(posedge clk);
    #3;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    checkOutput("async_reset_mid_show", {o1, o0, blank, digit_done, frame_done}, 5'b00_100);
    @(posedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, "post_reset_idle");
    applyStimulus(1'b1, 4'b1000, 2'd3, 1'b0, 1'b0, 1'b0, "post_reset_show");

    @(posedge clk);
    #3;
    checks++;
    if (sb.size() == 0) passes++;
    else $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
